// File: rtl/fill_engine.sv
// Framebuffer fill engine: CPU-programmed DST/COUNT/PAT/CTRL registers drive a
// word-write burst into video memory, one word per accepted beat, constant or incrementing pattern.
module fill_engine #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [1:0]        addr,
  input  logic              wmask,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata
);
  localparam int DW = ADDR_W - 2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dst;
  logic [CNT_W-1:0] count;
  logic [31:0]   pat;
  logic          inc, done, abort_pend;

  logic access, wr, ctrl_wr, start_wr, abort_wr, beat;
  logic start_run, start_zero, finish;
  logic [31:0] rd_mux;

  assign access   = valid & ~ready;
  assign wr       = access & wmask;
  assign ctrl_wr  = wr & (addr == 2'd3);
  assign start_wr = ctrl_wr & wdata[0];
  assign abort_wr = ctrl_wr & wdata[2];
  assign beat     = mem_valid & mem_ready;

  // Outputs come straight from the live registers, so they stay stable while stalled.
  assign mem_valid = (state == RUN);
  assign mem_wmask = {4{mem_valid}};
  assign mem_addr  = {dst, 2'b00};
  assign mem_wdata = pat;

  always_comb begin
    state_nxt  = state;
    start_run  = 1'b0;
    start_zero = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_wr) begin
          if (count != '0) begin
            start_run = 1'b1;
            state_nxt = RUN;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      RUN: begin
        // An abort only lands on an accepted beat; the beat in flight always completes.
        if (beat && (count == CNT_W'(1) || abort_pend || abort_wr)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0: rd_mux = 32'({dst, 2'b00});
      2'd1: rd_mux = 32'(count);
      2'd2: rd_mux = pat;
      2'd3: rd_mux = {29'b0, inc, done, state == RUN};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      rdata      <= '0;
      dst        <= '0;
      count      <= '0;
      pat        <= '0;
      inc        <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= access;
      rdata <= access ? rd_mux : '0;

      if (state == IDLE && wr) begin
        case (addr)
          2'd0: dst   <= wdata[ADDR_W-1:2];
          2'd1: count <= wdata[CNT_W-1:0];
          2'd2: pat   <= wdata;
          default: ;
        endcase
      end

      if (start_run) begin
        inc        <= wdata[1];
        done       <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (start_zero) done <= 1'b1;

      if (beat) begin
        dst   <= dst + DW'(1);
        count <= count - CNT_W'(1);
        pat   <= pat + 32'(inc);
      end

      if (state == RUN && abort_wr) abort_pend <= 1'b1;
      if (finish) begin
        done       <= 1'b1;
        abort_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fill_engine.sv
// Bench for fill_engine: a queue of expected beats plus a register model checked every cycle,
// driven by directed scenarios and randomized fills with random memory backpressure.
module tb_fill_engine;
  logic        clk = 0;
  logic        reset = 1;
  logic        valid = 0;
  logic        ready;
  logic [1:0]  addr = 0;
  logic        wmask = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic        mem_valid;
  logic        mem_ready = 0;
  logic [16:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;

  fill_engine #(.ADDR_W(17), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr),
    .wmask(wmask), .wdata(wdata), .rdata(rdata), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: expected beats as a list, registers as plain values.
  typedef struct packed { logic [16:0] a; logic [31:0] d; } beat_t;
  beat_t       q[$];
  logic [16:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [16:0] m_dst = 0;
  logic [15:0] m_count = 0;
  logic [31:0] m_pat = 0;
  logic        m_inc = 0, m_done = 0, m_abort = 0;
  logic [31:0] exp_rdata = 0;
  int          accepted = 0;

  always @(negedge clk) begin
    logic fire, busy, bt, abort_now;
    if (reset) begin
      q.delete();
      m_dst = 0; m_count = 0; m_pat = 0;
      m_inc = 0; m_done = 0; m_abort = 0;
      exp_rdata = 0;
    end else begin
      fire = valid && !ready;
      busy = (q.size() != 0);
      abort_now = 1'b0;
      chk("mem_valid", {31'b0, mem_valid}, {31'b0, busy});
      if (busy && mem_valid) begin
        chk("mem_addr", {15'b0, mem_addr}, {15'b0, q[0].a});
        chk("mem_wdata", mem_wdata, q[0].d);
        chk("mem_wmask", {28'b0, mem_wmask}, 32'hf);
      end else if (!mem_valid) begin
        chk("mem_wmask_idle", {28'b0, mem_wmask}, 32'h0);
      end
      if (!ready) chk("rdata_idle", rdata, 32'h0);
      bt = busy && mem_valid && mem_ready;

      if (fire) begin
        case (addr)
          2'd0: exp_rdata = {15'b0, m_dst};
          2'd1: exp_rdata = {16'b0, m_count};
          2'd2: exp_rdata = m_pat;
          default: exp_rdata = {29'b0, m_inc, m_done, busy};
        endcase
      end

      if (fire && wmask && !busy) begin
        case (addr)
          2'd0: m_dst = {wdata[16:2], 2'b00};
          2'd1: m_count = wdata[15:0];
          2'd2: m_pat = wdata;
          default: if (wdata[0]) begin
            if (m_count != 0) begin
              m_inc = wdata[1]; m_done = 0; m_abort = 0;
              for (int i = 0; i < m_count; i++)
                q.push_back('{a: m_dst + 17'(4 * i), d: m_pat + (wdata[1] ? 32'(i) : 32'd0)});
            end else begin
              m_done = 1;
            end
          end
        endcase
      end
      if (fire && wmask && addr == 2'd3 && wdata[2] && busy) abort_now = 1'b1;

      if (bt) begin
        void'(q.pop_front());
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_wdata);
        accepted++;
        m_dst = m_dst + 17'd4;
        m_count = m_count - 16'd1;
        m_pat = m_pat + {31'b0, m_inc};
        if (q.size() == 0) m_done = 1;
        else if (m_abort || abort_now) begin
          q.delete(); m_done = 1; m_abort = 0;
        end
      end else if (abort_now) begin
        m_abort = 1;
      end
    end
  end

  // mem_ready modes: 0 always ready, 1 toggling, 2 random
  int rmode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: mem_ready = 1'b1;
      1: mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    valid = 1; addr = a; wmask = w; wdata = d;
    @(negedge clk);
    chk("ready_early", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;
    valid = 0; wmask = 0;
    chk("ready_pulse", {31'b0, ready}, 32'h1);
    rd = rdata;
    chk("rdata", rdata, exp_rdata);
    @(posedge clk); #1;
    chk("ready_drop", {31'b0, ready}, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(a, 1'b1, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus(a, 1'b0, 32'h0, v);
    chk(name, v, exp);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!mem_valid && q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL wait_idle: engine still busy after 3000 cycles");
    end
  endtask

  task automatic wait_beats(input int n);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (accepted >= n) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL wait_beats: only %0d of %0d beats accepted", accepted, n);
    end
  endtask

  task automatic start_fill(input logic [31:0] d, input logic [31:0] c,
                            input logic [31:0] p, input logic [31:0] ctrl);
    wr(2'd0, d); wr(2'd1, c); wr(2'd2, p);
    log_addr.delete(); log_data.delete(); accepted = 0;
    wr(2'd3, ctrl);
  endtask

  initial begin
    logic [31:0] v;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_valid", {31'b0, mem_valid}, 32'h0);
    rd_chk("reset_ctrl", 2'd3, 32'h0);

    // Basic constant fill, always ready
    rmode = 0;
    start_fill(32'h1000, 4, 32'hdeadbeef, 32'h1);
    wait_idle();
    chk("basic_beats", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("basic_addr", {15'b0, log_addr[i]}, 32'h1000 + 32'(4 * i));
      chk("basic_data", log_data[i], 32'hdeadbeef);
    end
    rd_chk("basic_count", 2'd1, 32'h0);
    rd_chk("basic_dst", 2'd0, 32'h1010);
    rd_chk("basic_ctrl", 2'd3, 32'h2);

    // Incrementing pattern under toggling backpressure
    rmode = 1;
    start_fill(32'h20, 3, 7, 32'h3);
    wait_idle();
    chk("bp_beats", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk("bp_addr", {15'b0, log_addr[i]}, 32'h20 + 32'(4 * i));
      chk("bp_data", log_data[i], 32'(7 + i));
    end
    rd_chk("bp_pat", 2'd2, 32'd10);
    rd_chk("bp_ctrl", 2'd3, 32'h6);

    // Address wrap at the top of the window
    rmode = 0;
    start_fill(32'h1fffc, 2, 32'h55, 32'h1);
    wait_idle();
    chk("wrap_beats", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("wrap_addr0", {15'b0, log_addr[0]}, 32'h1fffc);
      chk("wrap_addr1", {15'b0, log_addr[1]}, 32'h0);
    end

    // Zero count: no traffic, done set immediately
    start_fill(32'h400, 0, 32'h1, 32'h1);
    chk("zero_no_valid", {31'b0, mem_valid}, 32'h0);
    rd_chk("zero_ctrl", 2'd3, 32'h2);
    chk("zero_beats", accepted, 0);

    // Abort mid-run; a START written while running is ignored
    start_fill(32'h2000, 100, 32'h0, 32'h1);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'h5);
    wait_beats(10);
    wr(2'd3, 32'h4);
    wait_idle();
    bus(2'd1, 1'b0, 32'h0, v);
    chk("abort_range", {31'b0, (v >= 80 && v <= 90)}, 32'h1);
    chk("abort_beats", accepted, 100 - int'(v));
    rd_chk("abort_ctrl", 2'd3, 32'h2);
    wr(2'd3, 32'h4);
    rd_chk("abort_idle_ctrl", 2'd3, 32'h2);

    // Randomized fills with random backpressure and reads while busy
    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      logic [31:0] c, ctl;
      c = $urandom_range(1, 12);
      ctl = {30'b0, 1'($urandom_range(0, 1)), 1'b1};
      start_fill($urandom, c, $urandom, ctl);
      for (int k = 0; k < 3; k++) begin
        bus(2'($urandom_range(0, 3)), 1'b0, 32'h0, v);
      end
      wait_idle();
      chk("rand_beats", accepted, int'(c));
      rd_chk("rand_ctrl", 2'd3, {29'b0, ctl[1], 2'b10});
    end

    // Reset while running
    rmode = 0;
    start_fill(32'h3000, 50, 32'h99, 32'h3);
    wait_beats(5);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    rd_chk("rst_dst", 2'd0, 32'h0);
    rd_chk("rst_count", 2'd1, 32'h0);
    rd_chk("rst_pat", 2'd2, 32'h0);
    rd_chk("rst_ctrl", 2'd3, 32'h0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
